// File: rtl/port_resp_reorder.sv
// Per-port response reorder buffer: tags are handed out in order, responses land in
// their tag's slot in any order, and are released to the requester strictly in issue order.
module port_resp_reorder #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [TAG_W-1:0]  resp_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              out_ready,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              err_unexp
);

    localparam int DEPTH = 1 << TAG_W;

    logic [TAG_W:0]    head_q, head_d;
    logic [TAG_W:0]    tail_q, tail_d;
    logic [DEPTH-1:0]  alloc_q, alloc_d;
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              err_q, err_d;

    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic              fill_ok;
    logic              pop;

    assign head_idx  = head_q[TAG_W-1:0];
    assign tail_idx  = tail_q[TAG_W-1:0];
    assign empty     = (head_q == tail_q);
    assign full      = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign count     = tail_q - head_q;

    // Grant looks only at start-of-cycle full, so a same-cycle pop never frees a slot early.
    assign alloc_gnt = alloc_req & ~full & ~rst;
    assign alloc_tag = tail_idx;

    // A slot still being allocated this cycle has alloc_q=0, so a response to it is rejected.
    assign fill_ok   = resp_valid & alloc_q[resp_tag] & ~filled_q[resp_tag];

    assign out_valid = ~empty & filled_q[head_idx];
    assign out_data  = data_q[head_idx];
    assign out_tag   = head_idx;
    assign pop       = out_valid & out_ready;
    assign err_unexp = err_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (alloc_gnt) begin
            tail_d = tail_q + 1'b1;
        end
        if (resp_valid && !fill_ok) begin
            err_d = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic pop_here;
            logic alloc_here;
            logic fill_here;

            assign pop_here   = pop       && (head_idx == TAG_W'(gi));
            assign alloc_here = alloc_gnt && (tail_idx == TAG_W'(gi));
            assign fill_here  = fill_ok   && (resp_tag == TAG_W'(gi));

            assign alloc_d[gi]  = (alloc_q[gi]  & ~pop_here) | alloc_here;
            assign filled_d[gi] = (filled_q[gi] & ~pop_here) | fill_here;
            assign data_d[gi]   = fill_here ? resp_data : data_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            alloc_q  <= '0;
            filled_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            err_q    <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_port_resp_reorder.sv
// Scoreboard bench for port_resp_reorder: tags are queued at grant, data recorded at
// legal fill, and each release is popped and compared in issue order.
module tb_port_resp_reorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [1:0]  alloc_tag;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [1:0]  resp_tag;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_tag;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        err_unexp;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    bit          m_alloc  [4];
    bit          m_filled [4];
    logic [15:0] m_data   [4];
    logic [1:0]  sb_q[$];
    int          m_tail;
    bit          m_err;

    // outputs sampled in the most recent cycle
    logic        s_gnt, s_ov, s_full, s_err;
    logic [1:0]  s_tag, s_ot;
    logic [15:0] s_od;
    logic [2:0]  s_cnt;

    port_resp_reorder #(.DATA_W(16), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_alloc[i]  = 1'b0;
            m_filled[i] = 1'b0;
            m_data[i]   = 16'h0;
        end
        sb_q.delete();
        m_tail = 0;
        m_err  = 1'b0;
    endtask

    task automatic idle_inputs();
        alloc_req  = 1'b0;
        resp_valid = 1'b0;
        resp_tag   = 2'd0;
        resp_data  = 16'h0;
        out_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; starts and ends just after a falling edge.
    task automatic cycle(input logic a_req, input logic r_v, input logic [1:0] r_tag,
                         input logic [15:0] r_data, input logic o_rdy);
        logic       exp_gnt, exp_ov, legal;
        logic [1:0] ft;
        alloc_req  = a_req;
        resp_valid = r_v;
        resp_tag   = r_tag;
        resp_data  = r_data;
        out_ready  = o_rdy;
        #1;
        s_gnt = alloc_gnt; s_tag = alloc_tag; s_ov = out_valid; s_od = out_data;
        s_ot = out_tag; s_cnt = count; s_full = full; s_err = err_unexp;

        exp_gnt = a_req && (sb_q.size() < 4);
        exp_ov  = (sb_q.size() > 0) && m_filled[sb_q[0]];
        legal   = r_v && m_alloc[r_tag] && !m_filled[r_tag];

        n_cmp++;
        if (alloc_gnt !== exp_gnt) begin
            n_err++; $display("FAIL alloc_gnt: got %b want %b", alloc_gnt, exp_gnt);
        end
        if (exp_gnt) begin
            n_cmp++;
            if (alloc_tag !== 2'(m_tail % 4)) begin
                n_err++; $display("FAIL alloc_tag: got %0d want %0d", alloc_tag, m_tail % 4);
            end
        end
        n_cmp++;
        if (out_valid !== exp_ov) begin
            n_err++; $display("FAIL out_valid: got %b want %b", out_valid, exp_ov);
        end
        n_cmp++;
        if (count !== 3'(sb_q.size())) begin
            n_err++; $display("FAIL count: got %0d want %0d", count, sb_q.size());
        end
        n_cmp++;
        if (full !== (sb_q.size() == 4) || empty !== (sb_q.size() == 0)) begin
            n_err++; $display("FAIL full_empty: got %b/%b want %b/%b", full, empty,
                              sb_q.size() == 4, sb_q.size() == 0);
        end
        n_cmp++;
        if (err_unexp !== m_err) begin
            n_err++; $display("FAIL err_unexp: got %b want %b", err_unexp, m_err);
        end

        if (exp_ov && o_rdy) begin
            ft = sb_q.pop_front();
            n_cmp++;
            if (out_tag !== ft || out_data !== m_data[ft]) begin
                n_err++; $display("FAIL release: got tag %0d data %h want tag %0d data %h",
                                  out_tag, out_data, ft, m_data[ft]);
            end
            $display("release tag=%0d data=%h", out_tag, out_data);
            m_alloc[ft]  = 1'b0;
            m_filled[ft] = 1'b0;
        end
        if (exp_gnt) begin
            m_alloc[m_tail % 4] = 1'b1;
            sb_q.push_back(2'(m_tail % 4));
            m_tail = (m_tail + 1) % 8;
        end
        if (r_v) begin
            if (legal) begin
                m_filled[r_tag] = 1'b1;
                m_data[r_tag]   = r_data;
            end else begin
                m_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        alloc_req = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (alloc_gnt !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || out_tag !== 2'd0 ||
            count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || alloc_tag !== 2'd0 || err_unexp !== 1'b0) begin
            n_err++; $display("FAIL reset_state: gnt %b ov %b od %h ot %0d cnt %0d em %b fu %b at %0d err %b",
                              alloc_gnt, out_valid, out_data, out_tag, count, empty, full, alloc_tag, err_unexp);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        cycle(1'b0, 1'b1, 2'd0, 16'hAAAA, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b0) begin n_err++; $display("FAIL inorder_nobypass: got %b want 0", s_ov); end
        cycle(1'b0, 1'b1, 2'd1, 16'hBBBB, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b1 || s_od !== 16'hAAAA) begin
            n_err++; $display("FAIL inorder_0: got %b/%h want 1/aaaa", s_ov, s_od);
        end
        cycle(1'b0, 1'b1, 2'd2, 16'hCCCC, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b1 || s_od !== 16'hBBBB) begin
            n_err++; $display("FAIL inorder_1: got %b/%h want 1/bbbb", s_ov, s_od);
        end
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b1 || s_od !== 16'hCCCC) begin
            n_err++; $display("FAIL inorder_2: got %b/%h want 1/cccc", s_ov, s_od);
        end
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_cnt !== 3'd0) begin n_err++; $display("FAIL inorder_count: got %0d want 0", s_cnt); end
    endtask

    task automatic test_reorder();
        logic [1:0] order [4];
        order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_gnt !== 1'b0 || s_full !== 1'b1) begin
            n_err++; $display("FAIL reorder_full: got gnt %b full %b want 0/1", s_gnt, s_full);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, order[i], 16'(order[i]), 1'b1);
            n_cmp++;
            if (s_ov !== 1'b0) begin n_err++; $display("FAIL reorder_wait%0d: got %b want 0", i, s_ov); end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
            n_cmp++;
            if (s_ov !== 1'b1 || s_od !== 16'(k) || s_ot !== 2'(k)) begin
                n_err++; $display("FAIL reorder_rel%0d: got %b/%h/%0d want 1/%h/%0d", k, s_ov, s_od, s_ot, k, k);
            end
        end
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_cnt !== 3'd0) begin n_err++; $display("FAIL reorder_count: got %0d want 0", s_cnt); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 2'd0, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
            n_cmp++;
            if (s_ov !== 1'b1 || s_od !== 16'h1234 || s_ot !== 2'd0) begin
                n_err++; $display("FAIL bp_hold%0d: got %b/%h/%0d want 1/1234/0", i, s_ov, s_od, s_ot);
            end
        end
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b0 || s_cnt !== 3'd0) begin
            n_err++; $display("FAIL bp_release: got ov %b cnt %0d want 0/0", s_ov, s_cnt);
        end
    endtask

    task automatic test_wrap_full();
        logic [15:0] d;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            d = 16'h5A00 + 16'(i);
            cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
            n_cmp++;
            if (s_gnt !== 1'b1 || s_tag !== 2'(i % 4)) begin
                n_err++; $display("FAIL wrap_tag%0d: got %b/%0d want 1/%0d", i, s_gnt, s_tag, i % 4);
            end
            cycle(1'b0, 1'b1, 2'(i % 4), d, 1'b1);
            cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
            n_cmp++;
            if (s_ov !== 1'b1 || s_od !== d) begin
                n_err++; $display("FAIL wrap_rel%0d: got %b/%h want 1/%h", i, s_ov, s_od, d);
            end
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 2'd2, 16'hF00D, 1'b0);
        n_cmp++;
        if (s_full !== 1'b1 || s_cnt !== 3'd4) begin
            n_err++; $display("FAIL wrap_full: got %b/%0d want 1/4", s_full, s_cnt);
        end
        cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_gnt !== 1'b0 || s_ov !== 1'b1) begin
            n_err++; $display("FAIL wrap_popgnt: got gnt %b ov %b want 0/1", s_gnt, s_ov);
        end
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        n_cmp++;
        if (s_cnt !== 3'd3 || s_full !== 1'b0) begin
            n_err++; $display("FAIL wrap_after: got cnt %0d full %b want 3/0", s_cnt, s_full);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        cycle(1'b0, 1'b1, 2'd2, 16'hDEAD, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        n_cmp++;
        if (s_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", s_err); end
        cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 2'd1, 16'h1111, 1'b0);
        cycle(1'b0, 1'b1, 2'd1, 16'h2222, 1'b0);
        cycle(1'b0, 1'b1, 2'd0, 16'h0F0F, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_od !== 16'h0F0F) begin n_err++; $display("FAIL err_t0: got %h want 0f0f", s_od); end
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b1 || s_od !== 16'h1111) begin
            n_err++; $display("FAIL err_first_kept: got %b/%h want 1/1111", s_ov, s_od);
        end
        cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_ov !== 1'b0 || s_ot !== 2'd2 || s_err !== 1'b1) begin
            n_err++; $display("FAIL err_t2_empty: got ov %b tag %0d err %b want 0/2/1", s_ov, s_ot, s_err);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        cycle(1'b0, 1'b1, 2'd0, 16'h5555, 1'b0);
        idle_inputs();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || count !== 3'd3) begin
            n_err++; $display("FAIL mid_pre: got ov %b cnt %0d want 1/3", out_valid, count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0 || alloc_tag !== 2'd0 || empty !== 1'b1) begin
            n_err++; $display("FAIL mid_async: got ov %b cnt %0d tag %0d empty %b want 0/0/0/1",
                              out_valid, count, alloc_tag, empty);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 2'd1, 16'h7777, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        n_cmp++;
        if (s_err !== 1'b1 || s_ov !== 1'b0) begin
            n_err++; $display("FAIL mid_post_err: got err %b ov %b want 1/0", s_err, s_ov);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_reorder();
        test_backpressure();
        test_wrap_full();
        test_errors();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/port_resp_reorder.md
# port_resp_reorder

Per-port response reorder buffer placed directly downstream of the bank output arbiter. Each port may have up to four reads outstanding, identified by a 2-bit request tag. The arbiter returns data in bank-completion order, with no backpressure. This block stores each response in the slot its tag names and releases responses to the requester strictly in issue order over a valid/ready handshake.

## Interface
- DATA_W, 16, response data width
- TAG_W, 2, tag width; buffer depth is 2^TAG_W (4)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  requester asks for a tag for a new request
- alloc_gnt  out  1  tag granted this cycle; combinational, alloc_req & ~full, forced 0 while rst is high
- alloc_tag  out  TAG_W  tag handed out; equals tail pointer low bits
- resp_valid  in  1  arbiter port valid
- resp_data  in  DATA_W  arbiter port data
- resp_tag  in  TAG_W  arbiter port request tag
- out_valid  out  1  in-order response available
- out_data  out  DATA_W  response data
- out_tag  out  TAG_W  tag of the released response
- out_ready  in  1  requester accepts the response
- count  out  TAG_W+1  outstanding allocations (0..4)
- full  out  1  count == 4
- empty  out  1  count == 0
- err_unexp  out  1  sticky flag: a response arrived for an unallocated or already-filled tag

## Operation
- Pointers:
  - head and tail are TAG_W+1 bits wide and wrap modulo 2^(TAG_W+1).
  - count = tail − head.
  - full is asserted when the low bits are equal and the MSBs differ.
  - empty is asserted when head == tail.
- Per-slot state: alloc bit, filled bit, DATA_W data register.
- Allocate:
  - Occurs when alloc_gnt is high.
  - Sets slot[tail].alloc and increments tail.
  - Grant uses full as sampled at the start of the cycle. A pop in the same cycle does not unblock a grant while full.
- Fill:
  - Occurs when resp_valid is high and slot[resp_tag] has alloc=1, filled=0 (state at the start of the cycle).
  - Writes the data and sets filled.
- Illegal response:
  - Any other resp_valid (tag not allocated, already filled, or being allocated in this same cycle) is dropped.
  - Sets err_unexp. err_unexp clears only on rst.
- Release:
  - out_valid = ~empty & slot[head].filled.
  - out_data and out_tag come from slot[head]; both are combinational from the registers.
  - On out_valid & out_ready, the slot's alloc and filled bits clear and head increments.
  - out_data and out_tag are held stable while out_valid is high and out_ready is low.
- Simultaneous events (all legal in one cycle, each acting on start-of-cycle state):
  - allocate + fill (different slot)
  - allocate + release
  - fill + release (different slot)
- No bypass: a fill of the head slot is visible on out_valid one cycle later.
- Reset (asynchronous):
  - head=tail=0; all alloc, filled, and data bits 0; err_unexp=0.
  - Resulting outputs: out_valid=0, out_data=0, out_tag=0, count=0, empty=1, full=0, alloc_tag=0.
- Reset mid-operation: all outstanding entries are discarded. Responses arriving after rst deasserts for pre-reset tags are treated as unexpected.

## Timing
- Allocate: combinational grant. Tail updates at the clock edge, so alloc_tag advances the next cycle.
- Response to out_valid: 1 cycle when the response is for the head slot. Otherwise out_valid waits until all older tags are filled and released.
- Throughput: one allocate, one fill, and one release per cycle sustained.
- Back-to-back releases occur with no bubble when consecutive slots are filled and out_ready is held high.
- All state registers are on clk rising edge with async clear on rst.

## Test plan
- In-order:
  - Stimulus: allocate tags 0,1,2; respond 0xAAAA/t0, 0xBBBB/t1, 0xCCCC/t2 on consecutive cycles; out_ready=1.
  - Required: out_valid one cycle after each response; data AAAA, BBBB, CCCC; count returns to 0.
- Reorder:
  - Stimulus: allocate 0..3 (full=1, alloc_gnt=0 on a 5th alloc_req); respond t3=0x0003, t1=0x0001, t2=0x0002, then t0=0x0000.
  - Required: out_valid stays 0 until the cycle after the t0 response; releases 0000, 0001, 0002, 0003 in order on 4 consecutive cycles.
- Backpressure:
  - Stimulus: t0 filled with 0x1234, out_ready=0 for 5 cycles.
  - Required: out_valid=1 with out_data=0x1234 and out_tag=0 stable for all 5 cycles; release occurs on the first cycle out_ready=1.
- Wrap and full:
  - Stimulus: run 10 allocate/fill/release rounds.
  - Required: alloc_tag sequence 0,1,2,3,0,1,…; full asserted only at count=4; alloc while full plus a pop in the same cycle gives alloc_gnt=0.
- Errors:
  - Stimulus: respond to an unallocated t2; then respond twice to allocated t1.
  - Required: err_unexp=1 after the first bad response and stays 1; slot t2 is not filled; t1 data is the first value received.
- Reset mid-flight:
  - Stimulus: 3 outstanding with t0 filled; assert rst asynchronously between edges.
  - Required: out_valid, count, and alloc_tag go to 0 immediately and empty goes to 1; a post-reset response to t1 sets err_unexp.
